// File: rtl/diag_pkg.sv
// Shared types and constants for the EBUS diagnostic function master.
package diag_pkg;

  localparam int unsigned DIAG_DWELL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } diagMasterState_t;

  localparam logic [0:6] DIAG_LD_FUNC_076   = 7'o076;
  localparam logic [0:6] DIAG_CLK_EDP       = 7'o077;
  localparam logic [0:6] DIAG_READ_FUNC_10x = 7'o100;

  // Dwell counters run from cyc-1 down to 0; a request of 0 cycles behaves as 1.
  function automatic logic [DIAG_DWELL_W-1:0] diag_dwell_load(input int unsigned cyc);
    if (cyc == 0) return '0;
    return DIAG_DWELL_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/diag_ebus_master_if.sv
// Command, response and EBUS signal bundle between the console master and its peers.
interface diag_ebus_master_if;

  logic        cmdValid;
  logic        cmdReady;
  logic [0:6]  cmdFunc;
  logic [0:35] cmdData;

  logic        rspValid;
  logic        rspReady;
  logic [0:35] rspData;
  logic        rspParErr;

  logic [0:6]  ebusDs;
  logic        ebusDiagStrobe;
  logic [0:35] ebusDataOut;
  logic        ebusDataDrive;
  logic [0:35] ebusDataIn;
  logic        ebusParityIn;

  modport master (
    input  cmdValid, cmdFunc, cmdData, rspReady, ebusDataIn, ebusParityIn,
    output cmdReady, rspValid, rspData, rspParErr,
           ebusDs, ebusDiagStrobe, ebusDataOut, ebusDataDrive
  );

  modport slave (
    output cmdValid, cmdFunc, cmdData, rspReady, ebusDataIn, ebusParityIn,
    input  cmdReady, rspValid, rspData, rspParErr,
           ebusDs, ebusDiagStrobe, ebusDataOut, ebusDataDrive
  );

endinterface

// File: rtl/diag_dwell_counter.sv
// Loadable down-counter with zero flag; times the SETUP, STROBE and HOLD phases.
module diag_dwell_counter
  import diag_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    load_i,
  input  logic [DIAG_DWELL_W-1:0] loadVal_i,
  input  logic                    dec_i,
  output logic                    zero_o
);

  logic [DIAG_DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= loadVal_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/diag_ebus_master.sv
// Console-side EBUS diagnostic initiator: one command at a time through
// setup / strobe / hold dwell phases, with read capture and parity check.
module diag_ebus_master
  import diag_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic               clk,
  input  logic               resetN,
  diag_ebus_master_if.master bus
);

  if ((SETUP_CYC > 15) || (STROBE_CYC > 15) || (HOLD_CYC > 15)) begin : g_param_err
    $error("diag_ebus_master: dwell parameters must be in 1..15");
  end

  localparam logic [DIAG_DWELL_W-1:0] SETUP_LD  = diag_dwell_load(SETUP_CYC);
  localparam logic [DIAG_DWELL_W-1:0] STROBE_LD = diag_dwell_load(STROBE_CYC);
  localparam logic [DIAG_DWELL_W-1:0] HOLD_LD   = diag_dwell_load(HOLD_CYC);

  diagMasterState_t state_q, state_d;

  logic                    cntLoad, cntDec, cntZero;
  logic [DIAG_DWELL_W-1:0] cntLoadVal;

  logic [0:6]  func_q;
  logic [0:35] data_q;
  logic        isRead_q;
  logic        accept;
  logic [0:6]  funcNext;
  logic [0:35] dataNext;
  logic        readNext;

  logic [0:6]  ds_q, ds_d;
  logic        strobe_q, strobe_d;
  logic [0:35] dout_q, dout_d;
  logic        drive_q, drive_d;
  logic        rspValid_q, rspValid_d;
  logic [0:35] rspData_q;
  logic        rspParErr_q;
  logic        sample;

  diag_dwell_counter u_dwell (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (cntLoad),
    .loadVal_i (cntLoadVal),
    .dec_i     (cntDec),
    .zero_o    (cntZero)
  );

  assign accept = (state_q == ST_IDLE) && bus.cmdValid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmdValid) begin
          state_d    = ST_SETUP;
          cntLoad    = 1'b1;
          cntLoadVal = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cntZero) begin
          state_d    = ST_STROBE;
          cntLoad    = 1'b1;
          cntLoadVal = STROBE_LD;
        end else begin
          cntDec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cntZero) begin
          state_d    = ST_HOLD;
          cntLoad    = 1'b1;
          cntLoadVal = HOLD_LD;
        end else begin
          cntDec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cntZero) state_d = ST_RESP;
        else         cntDec  = 1'b1;
      end
      ST_RESP: begin
        if (bus.rspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      func_q   <= '0;
      data_q   <= '0;
      isRead_q <= 1'b0;
    end else if (accept) begin
      func_q   <= bus.cmdFunc;
      data_q   <= bus.cmdData;
      isRead_q <= bus.cmdFunc[0];
    end
  end

  // Outputs are registered from the next state, so on the accept edge the
  // command fields must come straight from the inputs rather than the latches.
  assign funcNext = accept ? bus.cmdFunc    : func_q;
  assign dataNext = accept ? bus.cmdData    : data_q;
  assign readNext = accept ? bus.cmdFunc[0] : isRead_q;

  always_comb begin
    ds_d       = '0;
    strobe_d   = 1'b0;
    dout_d     = '0;
    drive_d    = 1'b0;
    rspValid_d = 1'b0;
    case (state_d)
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        ds_d     = funcNext;
        drive_d  = !readNext;
        dout_d   = readNext ? '0 : dataNext;
        strobe_d = (state_d == ST_STROBE);
      end
      ST_RESP: rspValid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ds_q       <= '0;
      strobe_q   <= 1'b0;
      dout_q     <= '0;
      drive_q    <= 1'b0;
      rspValid_q <= 1'b0;
    end else begin
      ds_q       <= ds_d;
      strobe_q   <= strobe_d;
      dout_q     <= dout_d;
      drive_q    <= drive_d;
      rspValid_q <= rspValid_d;
    end
  end

  // Read data is taken on the edge that ends the last strobe cycle.
  assign sample = (state_q == ST_STROBE) && cntZero && isRead_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rspData_q   <= '0;
      rspParErr_q <= 1'b0;
    end else if (accept) begin
      rspData_q   <= '0;
      rspParErr_q <= 1'b0;
    end else if (sample) begin
      rspData_q   <= bus.ebusDataIn;
      rspParErr_q <= ~^{bus.ebusDataIn, bus.ebusParityIn};
    end
  end

  assign bus.cmdReady       = (state_q == ST_IDLE);
  assign bus.rspValid       = rspValid_q;
  assign bus.rspData        = rspData_q;
  assign bus.rspParErr      = rspParErr_q;
  assign bus.ebusDs         = ds_q;
  assign bus.ebusDiagStrobe = strobe_q;
  assign bus.ebusDataOut    = dout_q;
  assign bus.ebusDataDrive  = drive_q;

endmodule

// File: doc/diag_ebus_master.md
# diag_ebus_master

Console-side initiator for the EBOX diagnostic function bus. Accepts one diagnostic function command at a time from the front-end, then sequences the EBUS diagnostic cycle: present `ds[0:6]` and load data, pulse `diagStrobe`, and for read functions capture and parity-check the returned `EBUS.data[0:35]`. It is the driving end of the function decode performed by the CTL board (0xx/07x load and control functions, 1xx read functions).

## Interface
- `SETUP_CYC`, default 2: cycles `ds` and data are stable before the strobe rises (1..15).
- `STROBE_CYC`, default 4: cycles `diagStrobe` is high (1..15).
- `HOLD_CYC`, default 2: cycles `ds` and data are held after the strobe falls (1..15).

Ports:
- `clk`  in  1  EBOX clock; the only clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `cmdValid`  in  1  command offered.
- `cmdReady`  out  1  command accepted on a cycle where valid and ready are both high.
- `cmdFunc`  in  7  function code in `[0:6]` order. `cmdFunc[0]`=1 selects a read (1xx); otherwise load/control.
- `cmdData`  in  36  load data in `[0:35]` order. Ignored for reads.
- `rspValid`  out  1  command complete.
- `rspReady`  in  1  response consumed.
- `rspData`  out  36  captured read data. Zero for loads.
- `rspParErr`  out  1  read parity mismatch. Zero for loads.
- `ebusDs`  out  7  diagnostic select to the EBUS.
- `ebusDiagStrobe`  out  1  diagnostic strobe.
- `ebusDataOut`  out  36  data driven for loads.
- `ebusDataDrive`  out  1  the master owns `EBUS.data`.
- `ebusDataIn`  in  36  EBUS data for reads.
- `ebusParityIn`  in  1  EBUS parity bit. Odd parity over the 36 data bits plus this bit.

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD, RESP.
- **IDLE**
  - `cmdReady`=1.
  - On accept, latch the function, the data and the read flag, load the dwell counter with `SETUP_CYC`-1, and go to SETUP.
- **SETUP**
  - `ebusDs` = latched function.
  - For loads: `ebusDataOut` = latched data and `ebusDataDrive`=1.
  - For reads: `ebusDataDrive`=0 and `ebusDataOut`=0.
  - When the counter reaches 0, go to STROBE with the counter set to `STROBE_CYC`-1.
- **STROBE**
  - As SETUP, plus `ebusDiagStrobe`=1.
  - For reads, `ebusDataIn` and `ebusParityIn` are registered into `rspData` and `rspParErr` on the clock edge that leaves STROBE, so the sample is taken in the last strobe cycle.
  - `rspParErr` = XNOR-reduce of {data, parity}, i.e. the count of ones is even.
- **HOLD**
  - As SETUP with `ebusDiagStrobe`=0.
  - At counter 0, go to RESP.
- **RESP**
  - `rspValid`=1.
  - `ebusDs`=0, `ebusDataDrive`=0, `ebusDataOut`=0.
  - `rspData` and `rspParErr` stay stable until `rspReady`, then go to IDLE.
  - For loads, `rspData`=0 and `rspParErr`=0.
- Only one command is in flight. A new command is never accepted while in RESP, including on the cycle `rspReady` is high. Earliest re-accept is the cycle after the return to IDLE.
- **Reset (asynchronous, any state):**
  - State goes to IDLE.
  - Every output is 0 except `cmdReady`, which is 1 once in IDLE.
  - `rspData` and `rspParErr` clear; the in-flight command is discarded and no response is produced.
- **Out-of-range parameters:** a value of 0 is treated as 1. Parameters are elaboration-time checked and an error is flagged if any value exceeds 15.

## Timing
- Accept on edge E0. Then SETUP occupies cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, and `rspValid` rises in cycle S+T+H+1 (S, T, H are the parameter values).
- Defaults give: strobe high in cycles 3–6, read data sampled at the end of cycle 6, `rspValid` from cycle 9.
- `ebusDs`, data and drive change only on IDLE→SETUP and HOLD→RESP edges, never while the strobe is high.
- All outputs are registered. There are no combinational paths from inputs to outputs other than `cmdReady`, which is decoded from state.

## Structure
- Shared package `diag_pkg` holds:
  - the state enum `diagMasterState_t`;
  - function constants `DIAG_LD_FUNC_076 = 7'o076`, `DIAG_CLK_EDP = 7'o077`, `DIAG_READ_FUNC_10x = 7'o100`;
  - the 4-bit dwell width constant.
- One sub-module: `diag_dwell_counter`, a loadable down-counter with a zero flag, shared by all three timed states.

## Test plan
- **Load 076 (defaults):** `cmdFunc`=7'o076, `cmdData`=36'h0_F000_0000. Expect `ebusDs`=7'o076 and `ebusDataDrive`=1 in cycles 1–8, strobe high in cycles 3–6 only, and `rspValid` in cycle 9 with `rspData`=0.
- **Read 100 (defaults):** `ebusDataIn`=36'h1_2345_6789 held stable, parity bit chosen so total parity is odd. Expect `ebusDataDrive`=0 throughout, `rspData`=36'h1_2345_6789 and `rspParErr`=0.
- **Read with bad parity:** `ebusDataIn`=0, `ebusParityIn`=0. Expect `rspParErr`=1.
- **Back-pressure:** hold `rspReady`=0 for 5 cycles with `cmdValid` held high. Expect `rspValid` and `rspData` stable and `cmdReady`=0 throughout. Release: IDLE follows, and the second command is accepted one cycle later.
- **Reset mid-strobe:** assert `resetN`=0 in cycle 4. Expect all EBUS outputs 0 asynchronously and no `rspValid` after release.
- **SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1:** expect strobe high only in cycle 2 and `rspValid` in cycle 4.
